apb_mem_arbiter: RTL

Two-port APB arbiter that shares a single memory-side APB slave between the instruction-fetch master and the data master of the execute/memory/writeback stage. Each requester sees a standard APB slave. The arbiter selects one owner, replays that owner's transfer on the shared bus, and stalls the other requester by holding its `pready` low. It sits between the core's two `apb_if.master` ports and the memory subsystem.

---
 rtl/apb_mem_arbiter_pkg.sv | 19 +
 rtl/apb_mem_arbiter_if.sv | 25 ++
 rtl/apb_mem_arbiter_pick.sv | 35 +++
 rtl/apb_mem_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/apb_mem_arbiter_pkg.sv
// Shared types for the two-port APB memory arbiter.
// APB_ARB_ROUND_ROBIN_EN selects round-robin tie breaking (default: dmem has fixed priority).
package apb_mem_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE   = 2'd0;
   localparam logic [1:0] ARB_SETUP  = 2'd1;
   localparam logic [1:0] ARB_ACCESS = 2'd2;

   typedef enum logic {
      ARB_OWN_IMEM = 1'b0,
      ARB_OWN_DMEM = 1'b1
   } arb_owner_e;

   // One-hot request-vector position of an owner: bit 0 imem, bit 1 dmem.
   function automatic logic [1:0] owner_mask(input arb_owner_e own);
      return (own == ARB_OWN_DMEM) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/apb_mem_arbiter_if.sv
// APB bus bundle shared by both requesters and the downstream memory port.
interface apb_if #(
   parameter int DAT_W  = 32,
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0]  paddr;
   logic               psel;
   logic               penable;
   logic               pwrite;
   logic [DAT_W-1:0]   pwdata;
   logic [DAT_W/8-1:0] pstrb;
   logic [DAT_W-1:0]   prdata;
   logic               pready;
   logic               pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_mem_arbiter_pick.sv
// Combinational winner selection for the APB arbiter.
// APB_ARB_ROUND_ROBIN_EN: ties go to the requester that is not 'last'; otherwise dmem wins ties.
module apb_arb_pick
   import apb_mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  arb_owner_e last,
   input  logic [1:0] excl,
   output logic       gnt_valid,
   output arb_owner_e gnt_owner
);

   logic [1:0] cand;

`ifndef APB_ARB_ROUND_ROBIN_EN
   logic unused_last;
   assign unused_last = last;
`endif

   always_comb begin
      cand      = req & ~excl;
      gnt_valid = |cand;
      gnt_owner = ARB_OWN_IMEM;
      if (cand == 2'b11) begin
`ifdef APB_ARB_ROUND_ROBIN_EN
         gnt_owner = (last == ARB_OWN_DMEM) ? ARB_OWN_IMEM : ARB_OWN_DMEM;
`else
         gnt_owner = ARB_OWN_DMEM;
`endif
      end else if (cand[1]) begin
         gnt_owner = ARB_OWN_DMEM;
      end
   end

endmodule

// File: rtl/apb_mem_arbiter.sv
// Shares one downstream APB slave between the instruction-fetch and data masters.
// APB_ARB_ROUND_ROBIN_EN enables round-robin tie breaking and the 'last' register.
module apb_mem_arbiter
   import apb_mem_arbiter_pkg::*;
#(
   parameter int DAT_W  = 32,
   parameter int ADDR_W = 32
) (
   input  logic  clk,
   input  logic  rst,
   apb_if.slave  imem_apb,
   apb_if.slave  dmem_apb,
   apb_if.master mem_apb,
   output logic  owner_o,
   output logic  busy_o
);

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   arb_owner_e         owner;
   arb_owner_e         last;
   logic [1:0]         req;
   logic [1:0]         excl;
   logic               gnt_valid;
   arb_owner_e         gnt_owner;
   logic               grant;
   logic               busy;
   logic               access;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DAT_W-1:0]   sel_wdata;
   logic [DAT_W/8-1:0] sel_strb;
   logic               sel_write;
   logic               rsp;

   assign req    = {dmem_apb.psel, imem_apb.psel};
   assign busy   = (state == ARB_SETUP) || (state == ARB_ACCESS);
   assign access = (state == ARB_ACCESS);
   // The owner's psel is still high on its completion cycle, so mask it out there.
   assign excl   = access ? owner_mask(owner) : 2'b00;

   apb_arb_pick u_pick (
      .req       (req),
      .last      (last),
      .excl      (excl),
      .gnt_valid (gnt_valid),
      .gnt_owner (gnt_owner)
   );

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (gnt_valid) begin
               grant     = 1'b1;
               state_nxt = ARB_SETUP;
            end
         end
         ARB_SETUP:  state_nxt = ARB_ACCESS;
         ARB_ACCESS: begin
            if (mem_apb.pready) begin
               if (gnt_valid) begin
                  grant     = 1'b1;
                  state_nxt = ARB_SETUP;
               end else begin
                  state_nxt = ARB_IDLE;
               end
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ARB_IDLE;
         owner <= ARB_OWN_IMEM;
      end else begin
         state <= state_nxt;
         if (grant) owner <= gnt_owner;
      end
   end

`ifdef APB_ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last <= ARB_OWN_IMEM;
      else if (grant) last <= gnt_owner;
   end
`else
   assign last = ARB_OWN_IMEM;
`endif

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_strb  = '0;
      sel_write = 1'b0;
      if (busy) begin
         if (owner == ARB_OWN_DMEM) begin
            sel_addr  = dmem_apb.paddr;
            sel_wdata = dmem_apb.pwdata;
            sel_strb  = dmem_apb.pstrb;
            sel_write = dmem_apb.pwrite;
         end else begin
            sel_addr  = imem_apb.paddr;
            sel_wdata = imem_apb.pwdata;
            sel_strb  = imem_apb.pstrb;
            sel_write = imem_apb.pwrite;
         end
      end
   end

   assign mem_apb.psel    = busy;
   assign mem_apb.penable = access;
   assign mem_apb.paddr   = sel_addr;
   assign mem_apb.pwdata  = sel_wdata;
   assign mem_apb.pstrb   = sel_strb;
   assign mem_apb.pwrite  = sel_write;

   // Response is only meaningful in ACCESS; outside it the slave's outputs are ignored.
   assign rsp = access && mem_apb.pready;

   always_comb begin
      imem_apb.pready  = 1'b0;
      imem_apb.prdata  = '0;
      imem_apb.pslverr = 1'b0;
      dmem_apb.pready  = 1'b0;
      dmem_apb.prdata  = '0;
      dmem_apb.pslverr = 1'b0;
      if (rsp) begin
         if (owner == ARB_OWN_DMEM) begin
            dmem_apb.pready  = 1'b1;
            dmem_apb.prdata  = mem_apb.prdata;
            dmem_apb.pslverr = mem_apb.pslverr;
         end else begin
            imem_apb.pready  = 1'b1;
            imem_apb.prdata  = mem_apb.prdata;
            imem_apb.pslverr = mem_apb.pslverr;
         end
      end
   end

   assign owner_o = (owner == ARB_OWN_DMEM);
   assign busy_o  = busy;

endmodule
